// File: rtl/fp_result_collector.sv
// fp_result_collector: tags issued FP ops and captures their returning result/flags into a FIFO.
// Latency: entry captured LATENCY cycles after issue and visible on out_* one edge later.
// Backpressure: valid/ready drain; when full with no pop, completions are dropped and counted.
// Optional build macro FP_COLLECT_CANON_EN: canonicalise NaNs and NaN-box single results on capture.
module fp_result_collector #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     iss_enable,
    input  logic [1:0]               iss_fmt,
    input  logic                     iss_int,
    input  logic [63:0]              fp_result,
    input  logic [4:0]               fp_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_result,
    output logic [4:0]               out_flags,
    output logic [TAG_W-1:0]         out_tag,
    output logic [1:0]               out_fmt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [1:0]       fmt;
        logic             intr;
    } stage_t;

    typedef struct packed {
        logic [63:0]      result;
        logic [4:0]       flags;
        logic [TAG_W-1:0] tag;
        logic [1:0]       fmt;
    } entry_t;

    stage_t           stg [LATENCY];
    logic [TAG_W-1:0] tag_ctr;
    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [63:0]      cap_result;
    entry_t           cap_entry;
    entry_t           head;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;

`ifdef FP_COLLECT_CANON_EN
    // Integer/compare results are raw bit patterns and must never be rewritten.
    function automatic logic [63:0] canon(input logic [63:0] r, input logic [1:0] fmt,
                                          input logic intr);
        logic [63:0] res;
        res = r;
        if (!intr) begin
            if (fmt == 2'd0) begin
                if (r[30:23] == 8'hFF && r[22:0] != 23'd0)
                    res = 64'hFFFF_FFFF_7FC0_0000;
                else
                    res = {32'hFFFF_FFFF, r[31:0]};
            end else if (fmt == 2'd1 && r[62:52] == 11'h7FF && r[51:0] != 52'd0) begin
                res = 64'h7FF8_0000_0000_0000;
            end
        end
        return res;
    endfunction

    assign cap_result = canon(fp_result, stg[LATENCY-1].fmt, stg[LATENCY-1].intr);
`else
    // The int bit only matters for canonicalisation; it still rides the pipeline.
    logic unused_int;
    assign unused_int = stg[LATENCY-1].intr;
    assign cap_result = fp_result;
`endif

    assign cap_entry = {cap_result, fp_flags, stg[LATENCY-1].tag, stg[LATENCY-1].fmt};

    // Ops still in flight when clear is asserted must not land in the FIFO.
    assign push  = stg[LATENCY-1].vld && !clear;
    assign full  = (count == CW'(DEPTH));
    assign pop   = out_valid && out_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // Tracking pipeline and sequence tag; issue in the clear cycle is discarded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
            tag_ctr <= '0;
        end else if (clear) begin
            for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
            tag_ctr <= '0;
        end else begin
            stg[0] <= '{vld: iss_enable, tag: tag_ctr, fmt: iss_fmt, intr: iss_int};
            for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
            if (iss_enable) tag_ctr <= tag_ctr + TAG_W'(1);
        end
    end

    // Storage array; when full with a pop the tail slot is the one being vacated.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= cap_entry;
    end

    // Pointers, occupancy and drop accounting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)
                count <= count + CW'(1);
            else if (!wr_en && pop)
                count <= count - CW'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Head is gated so an empty FIFO presents all-zero fields.
    assign head       = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign out_result = out_valid ? head.result : 64'd0;
    assign out_flags  = out_valid ? head.flags  : 5'd0;
    assign out_tag    = out_valid ? head.tag    : '0;
    assign out_fmt    = out_valid ? head.fmt    : 2'd0;

endmodule
